i2c_master_seq: RTL and testbench
=================================

# i2c_master_seq

Single-byte I2C bus master that sequences complete transactions (START, 7-bit address + R/W, ACK, one data byte, ACK/NACK, STOP) for the existing I2C slave. A host issues one command through a valid/ready handshake and gets a one-cycle response pulse carrying read data and NACK status. The block drives SCL push-pull and SDA open-drain, so it shares the single bidirectional SDA wire with the slave.

## Interface
- CLK_DIV, 4: system clocks per SCL quarter-period, ≥2; one bit period = 4*CLK_DIV clocks
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_addr  in  7  target slave address
- cmd_rw  in  1  0 = write, 1 = read
- cmd_wdata  in  8  write data byte
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  8  read byte; 0 for writes and on NACK
- rsp_nack  out  1  a NACK occurred, or the read was rejected
- busy  out  1  transaction in progress (state ≠ IDLE)
- scl_o  out  1  SCL, push-pull
- sda_oe  out  1  1 = pull SDA low, 0 = release (external mux drives 1'bz)
- sda_i  in  1  sampled SDA line

## Operation
- States: IDLE → START → ADDR (8 bits) → ADDR_ACK → DATA (8 bits) → DATA_ACK → STOP → IDLE.
- Accept on cmd_valid & cmd_ready. cmd_ready = 1 only in IDLE. cmd_addr, cmd_rw and cmd_wdata are latched at acceptance.
- Address byte is {cmd_addr, cmd_rw}, sent MSB first.
- ADDR_ACK samples sda_i = 1 → NACK: rsp_nack is set and the state goes directly to STOP, skipping DATA.
- Write: DATA shifts out cmd_wdata MSB first. In DATA_ACK, sda_i = 1 sets rsp_nack.
- Read (only when the macro is defined): in DATA, sda_oe = 0 and the bit is shifted into rsp_rdata MSB first. In DATA_ACK the master releases SDA (NACK, last byte).
- rsp_valid pulses in the cycle the state returns to IDLE. cmd_ready is also 1 in that cycle, so back-to-back commands are legal.
- Reset values: scl_o = 1, sda_oe = 0, cmd_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_nack = 0, busy = 0, state = IDLE, divider = 0.
- Reset mid-transaction: the bus is released immediately (asynchronously), no rsp_valid is produced, and the command is dropped.

## Timing
- A quarter tick fires every CLK_DIV clocks. Quarters q0 and q1 have SCL low; q2 and q3 have SCL high.
- Data/ACK bit timing:
  - sda_oe changes only at q1 entry.
  - sda_i is sampled on the last clock of q2.
- START: q0–q1 have SCL = 1 and SDA released. At q2 sda_oe = 1 with SCL = 1, held through q3.
- STOP:
  - q0–q1: SCL = 0, sda_oe = 1.
  - q2: SCL = 1, sda_oe = 1.
  - q3: SCL = 1, sda_oe = 0.
- Latency, acceptance to rsp_valid:
  - Full transaction: 20 bit periods = 80*CLK_DIV clocks (320 at default).
  - Address NACK: 11 bit periods = 44*CLK_DIV clocks (176 at default).
- SDA never changes while SCL = 1, except for the START and STOP edges.

## Configuration
- I2C_MASTER_READ_EN defined: cmd_rw = 1 performs the read sequence above.
- Macro undefined: a command with cmd_rw = 1 is accepted, but there is no bus activity. rsp_valid pulses 1 clock after acceptance, with rsp_nack = 1 and rsp_rdata = 0. Write behaviour is unchanged.

## Structure
- Package i2c_pkg:
  - State enum.
  - Quarter index constants Q0–Q3.
  - I2C_ADDR_W = 7.
  - Bit count constant (8).
- Sub-module i2c_tick_gen: CLK_DIV counter producing a quarter tick and a 2-bit quarter index. It resets to 0 and is held cleared in IDLE.
- Top level: FSM, 3-bit bit counter, 8-bit shift register.

## Test plan
- Write, slave ACKs (CLK_DIV = 4): addr 7'h50, wdata 8'hA5 → bus shows byte 8'hA0 then 8'hA5. rsp_valid at +320 clocks with rsp_nack = 0 and rsp_rdata = 0.
- Address NACK (no slave pulls SDA): addr 7'h21 → STOP follows ADDR_ACK with no DATA phase. rsp_valid at +176 clocks with rsp_nack = 1.
- Read (macro defined): slave returns 8'h3C → rsp_rdata = 8'h3C, rsp_nack = 0, and the master releases SDA in DATA_ACK.
- Read (macro undefined): cmd_rw = 1 → scl_o stays 1 and sda_oe stays 0. rsp_valid 1 clock after acceptance with rsp_nack = 1.
- Back-to-back: cmd_valid held high with two writes → the second is accepted in the same cycle as the first rsp_valid. Exactly two START/STOP pairs appear.
- Reset mid-DATA: rst_n low during bit 3 → scl_o = 1 and sda_oe = 0 immediately, no rsp_valid. After release, cmd_ready = 1 and a new write completes normally.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types and constants for the single-byte I2C master sequencer.
`timescale 1ns/1ps
package i2c_pkg;

    localparam int I2C_ADDR_W = 7;
    localparam int I2C_BITS   = 8;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_START    = 3'd1,
        ST_ADDR     = 3'd2,
        ST_ADDR_ACK = 3'd3,
        ST_DATA     = 3'd4,
        ST_DATA_ACK = 3'd5,
        ST_STOP     = 3'd6
    } i2c_state_e;

endpackage

// File: rtl/i2c_tick_gen.sv
// Quarter-period tick generator: one tick every CLK_DIV clocks plus a
// free-running 2-bit quarter index, both held at zero while clear is high.
`timescale 1ns/1ps
module i2c_tick_gen
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    output logic       tick,
    output logic [1:0] quarter
);

    localparam int              CNT_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] div_reg;
    logic [1:0]       quarter_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_reg     <= '0;
            quarter_reg <= Q0;
        end else if (clear) begin
            div_reg     <= '0;
            quarter_reg <= Q0;
        end else if (div_reg == CNT_MAX) begin
            div_reg     <= '0;
            quarter_reg <= quarter_reg + 2'd1;
        end else begin
            div_reg     <= div_reg + CNT_W'(1);
        end
    end

    assign tick    = !clear && (div_reg == CNT_MAX);
    assign quarter = quarter_reg;

endmodule

// File: rtl/i2c_master_seq.sv
// Single-byte I2C master: START, address+R/W, ACK, one data byte, ACK, STOP.
// Reads are only performed when I2C_MASTER_READ_EN is defined; otherwise they are rejected.
`timescale 1ns/1ps
module i2c_master_seq
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [I2C_ADDR_W-1:0] cmd_addr,
    input  logic                  cmd_rw,
    input  logic [7:0]            cmd_wdata,
    output logic                  rsp_valid,
    output logic [7:0]            rsp_rdata,
    output logic                  rsp_nack,
    output logic                  busy,
    output logic                  scl_o,
    output logic                  sda_oe,
    input  logic                  sda_i
);

`ifdef I2C_MASTER_READ_EN
    localparam logic READ_EN = 1'b1;
`else
    localparam logic READ_EN = 1'b0;
`endif

    i2c_state_e  state_reg, state_next;
    logic [2:0]  bit_cnt_reg;
    logic [7:0]  shift_reg;
    logic [7:0]  wdata_reg;
    logic        rw_reg;
    logic        reject_reg;
    logic        scl_reg, scl_next;
    logic        sda_oe_reg;
    logic        rsp_valid_reg;
    logic [7:0]  rsp_rdata_reg;
    logic        rsp_nack_reg;

    logic        tick;
    logic [1:0]  quarter, quarter_next;
    logic        last_bit;
    logic        is_idle;

    assign is_idle  = (state_reg == ST_IDLE);
    assign last_bit = (bit_cnt_reg == 3'(I2C_BITS - 1));

    i2c_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (is_idle),
        .tick    (tick),
        .quarter (quarter)
    );

    always_comb begin
        state_next   = state_reg;
        quarter_next = tick ? quarter + 2'd1 : quarter;
        case (state_reg)
            ST_IDLE:     if (cmd_valid) state_next = ST_START;
            ST_START: begin
                if (reject_reg)                state_next = ST_IDLE;
                else if (tick && quarter == Q3) state_next = ST_ADDR;
            end
            ST_ADDR:     if (tick && quarter == Q3 && last_bit) state_next = ST_ADDR_ACK;
            ST_ADDR_ACK: if (tick && quarter == Q3) state_next = rsp_nack_reg ? ST_STOP : ST_DATA;
            ST_DATA:     if (tick && quarter == Q3 && last_bit) state_next = ST_DATA_ACK;
            ST_DATA_ACK: if (tick && quarter == Q3) state_next = ST_STOP;
            ST_STOP:     if (tick && quarter == Q3) state_next = ST_IDLE;
            default:     state_next = ST_IDLE;
        endcase
        // SCL follows the quarter index (low in q0/q1) except around START and in IDLE.
        if (state_next == ST_IDLE || state_next == ST_START)
            scl_next = 1'b1;
        else
            scl_next = quarter_next[1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            bit_cnt_reg   <= '0;
            shift_reg     <= '0;
            wdata_reg     <= '0;
            rw_reg        <= 1'b0;
            reject_reg    <= 1'b0;
            scl_reg       <= 1'b1;
            sda_oe_reg    <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= '0;
            rsp_nack_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            scl_reg       <= scl_next;
            rsp_valid_reg <= (state_reg != ST_IDLE) && (state_next == ST_IDLE);
            case (state_reg)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        shift_reg     <= {cmd_addr, cmd_rw};
                        wdata_reg     <= cmd_wdata;
                        rw_reg        <= cmd_rw;
                        reject_reg    <= cmd_rw && !READ_EN;
                        rsp_nack_reg  <= cmd_rw && !READ_EN;
                        rsp_rdata_reg <= '0;
                        bit_cnt_reg   <= '0;
                    end
                end
                ST_START: begin
                    if (tick && quarter == Q1) sda_oe_reg <= 1'b1;
                end
                ST_ADDR, ST_DATA: begin
                    if (tick) begin
                        if (quarter == Q0) begin
                            if (state_reg == ST_ADDR || !rw_reg)
                                sda_oe_reg <= ~shift_reg[7];
                            else
                                sda_oe_reg <= 1'b0;
                        end
                        if (quarter == Q2 && state_reg == ST_DATA && rw_reg)
                            rsp_rdata_reg <= {rsp_rdata_reg[6:0], sda_i};
                        if (quarter == Q3) begin
                            bit_cnt_reg <= bit_cnt_reg + 3'd1;
                            if (state_reg == ST_ADDR && last_bit)
                                shift_reg <= wdata_reg;
                            else
                                shift_reg <= {shift_reg[6:0], 1'b0};
                        end
                    end
                end
                ST_ADDR_ACK, ST_DATA_ACK: begin
                    // The master always releases SDA here; on reads that is the final NACK.
                    if (tick) begin
                        if (quarter == Q0) sda_oe_reg <= 1'b0;
                        if (quarter == Q2 && sda_i && (state_reg == ST_ADDR_ACK || !rw_reg))
                            rsp_nack_reg <= 1'b1;
                        if (quarter == Q3 && state_next == ST_STOP)
                            sda_oe_reg <= 1'b1;
                    end
                end
                ST_STOP: begin
                    if (tick && quarter == Q2) sda_oe_reg <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign cmd_ready = is_idle;
    assign busy      = !is_idle;
    assign scl_o     = scl_reg;
    assign sda_oe    = sda_oe_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_rdata = rsp_rdata_reg;
    assign rsp_nack  = rsp_nack_reg;

endmodule

// File: tb/tb_i2c_master_seq.sv
// Directed bench for i2c_master_seq with a behavioural open-drain slave on the shared SDA wire.
`timescale 1ns/1ps
module tb_i2c_master_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [6:0] cmd_addr = '0;
    logic       cmd_rw = 1'b0;
    logic [7:0] cmd_wdata = '0;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_nack;
    logic       busy;
    logic       scl_o;
    logic       sda_oe;
    logic       sda_line;

    int checks = 0;
    int failures = 0;

    // Slave model state (written only by the monitor process)
    logic       slave_pull = 1'b0;
    logic       prev_scl = 1'b1;
    logic       prev_sda = 1'b1;
    logic       in_txn = 1'b0;
    logic       seen_pos = 1'b0;
    logic       rw_bit = 1'b0;
    logic       acked = 1'b0;
    logic       mst_ack_oe = 1'b1;
    logic [7:0] shreg = '0;
    int         bitn = 0;
    int         frame = 0;
    int         start_cnt = 0;
    int         stop_cnt = 0;
    logic [7:0] bus_bytes[$];

    localparam logic [6:0] SLAVE_ADDR = 7'h50;
    localparam logic [7:0] RD_BYTE    = 8'h3C;

    assign sda_line = !(sda_oe || slave_pull);

    always #5 clk = ~clk;

    i2c_master_seq #(.CLK_DIV(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_rw    (cmd_rw),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_nack  (rsp_nack),
        .busy      (busy),
        .scl_o     (scl_o),
        .sda_oe    (sda_oe),
        .sda_i     (sda_line)
    );

    // Bus monitor + slave, evaluated on the inactive clock edge.
    always @(negedge clk) begin
        logic sda_now;
        sda_now = !(sda_oe || slave_pull);
        if (!rst_n) begin
            in_txn = 1'b0; slave_pull = 1'b0; bitn = 0; frame = 0; seen_pos = 1'b0;
        end else if (prev_scl && scl_o && prev_sda && !sda_now) begin
            start_cnt++; in_txn = 1'b1; bitn = 0; frame = 0; seen_pos = 1'b0;
            mst_ack_oe = 1'b1; acked = 1'b0;
        end else if (prev_scl && scl_o && !prev_sda && sda_now) begin
            stop_cnt++; in_txn = 1'b0; slave_pull = 1'b0;
        end else if (in_txn && !prev_scl && scl_o) begin
            seen_pos = 1'b1;
            if (bitn < 8) shreg = {shreg[6:0], sda_now};
            else if (frame == 1 && rw_bit) mst_ack_oe = sda_oe;
        end else if (in_txn && prev_scl && !scl_o && seen_pos) begin
            bitn++;
            if (bitn == 8) begin
                bus_bytes.push_back(shreg);
                if (frame == 0) begin
                    rw_bit = shreg[0];
                    acked = (shreg[7:1] == SLAVE_ADDR);
                    slave_pull = acked;
                end else begin
                    slave_pull = !rw_bit;
                end
            end else if (bitn == 9) begin
                bitn = 0; frame++; slave_pull = 1'b0;
                if (frame == 1 && acked && rw_bit) slave_pull = !RD_BYTE[7];
            end else if (frame == 1 && acked && rw_bit) begin
                slave_pull = !RD_BYTE[7 - bitn];
            end
        end
        prev_scl = scl_o;
        prev_sda = !(sda_oe || slave_pull);
    end

    // Issue one command and wait for rsp_valid; lat counts clocks from the acceptance edge.
    task automatic run_cmd(input logic [6:0] a, input logic rw, input logic [7:0] wd,
                           output int lat, output logic nack, output logic [7:0] rdata,
                           output logic bus_act);
        @(negedge clk);
        cmd_addr = a; cmd_rw = rw; cmd_wdata = wd; cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        lat = 0; bus_act = 1'b0; nack = 1'bx; rdata = 'x;
        while (lat < 2000) begin
            @(posedge clk);
            lat++;
            #1;
            if (scl_o !== 1'b1 || sda_oe !== 1'b0) bus_act = 1'b1;
            if (rsp_valid === 1'b1) begin
                nack = rsp_nack; rdata = rsp_rdata;
                break;
            end
        end
        if (lat >= 2000) begin
            failures++;
            $display("FAIL cmd_timeout: no rsp_valid within %0d clocks", lat);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (scl_o !== 1'b1)     begin failures++; $display("FAIL reset_scl: got %b want 1", scl_o); end
        checks++; if (sda_oe !== 1'b0)    begin failures++; $display("FAIL reset_sda_oe: got %b want 0", sda_oe); end
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        checks++; if (rsp_rdata !== 8'h00) begin failures++; $display("FAIL reset_rsp_rdata: got %h want 00", rsp_rdata); end
        checks++; if (rsp_nack !== 1'b0)  begin failures++; $display("FAIL reset_rsp_nack: got %b want 0", rsp_nack); end
        checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
        $display("test_reset: done");
    endtask

    task automatic test_write;
        int lat; logic nack; logic [7:0] rd; logic act;
        int b0, s0, p0;
        b0 = bus_bytes.size(); s0 = start_cnt; p0 = stop_cnt;
        run_cmd(7'h50, 1'b0, 8'hA5, lat, nack, rd, act);
        checks++; if (lat != 320)  begin failures++; $display("FAIL write_latency: got %0d want 320", lat); end
        checks++; if (nack !== 1'b0) begin failures++; $display("FAIL write_nack: got %b want 0", nack); end
        checks++; if (rd !== 8'h00)  begin failures++; $display("FAIL write_rdata: got %h want 00", rd); end
        @(posedge clk); #1;
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL write_pulse_width: got %b want 0", rsp_valid); end
        checks++; if (bus_bytes.size() != b0 + 2) begin
            failures++; $display("FAIL write_byte_count: got %0d want 2", bus_bytes.size() - b0);
        end else begin
            if (bus_bytes[b0] !== 8'hA0 || bus_bytes[b0+1] !== 8'hA5) begin
                failures++; $display("FAIL write_bytes: got %h %h want a0 a5", bus_bytes[b0], bus_bytes[b0+1]);
            end
        end
        checks++; if (start_cnt - s0 != 1 || stop_cnt - p0 != 1) begin
            failures++; $display("FAIL write_start_stop: got %0d/%0d want 1/1", start_cnt - s0, stop_cnt - p0);
        end
        $display("test_write: addr=50 wdata=a5 lat=%0d nack=%b rdata=%h", lat, nack, rd);
    endtask

    task automatic test_addr_nack;
        int lat; logic nack; logic [7:0] rd; logic act;
        int b0, s0, p0;
        b0 = bus_bytes.size(); s0 = start_cnt; p0 = stop_cnt;
        run_cmd(7'h21, 1'b0, 8'h77, lat, nack, rd, act);
        checks++; if (lat != 176)    begin failures++; $display("FAIL nack_latency: got %0d want 176", lat); end
        checks++; if (nack !== 1'b1) begin failures++; $display("FAIL nack_flag: got %b want 1", nack); end
        checks++; if (rd !== 8'h00)  begin failures++; $display("FAIL nack_rdata: got %h want 00", rd); end
        checks++; if (bus_bytes.size() != b0 + 1 || bus_bytes[b0] !== 8'h42) begin
            failures++; $display("FAIL nack_bytes: got count %0d want 1 byte 42", bus_bytes.size() - b0);
        end
        checks++; if (start_cnt - s0 != 1 || stop_cnt - p0 != 1) begin
            failures++; $display("FAIL nack_start_stop: got %0d/%0d want 1/1", start_cnt - s0, stop_cnt - p0);
        end
        $display("test_addr_nack: addr=21 lat=%0d nack=%b", lat, nack);
    endtask

    task automatic test_read;
        int lat; logic nack; logic [7:0] rd; logic act;
        int s0;
        s0 = start_cnt;
        run_cmd(7'h50, 1'b1, 8'h00, lat, nack, rd, act);
`ifdef I2C_MASTER_READ_EN
        checks++; if (lat != 320)    begin failures++; $display("FAIL read_latency: got %0d want 320", lat); end
        checks++; if (rd !== RD_BYTE) begin failures++; $display("FAIL read_rdata: got %h want 3c", rd); end
        checks++; if (nack !== 1'b0) begin failures++; $display("FAIL read_nack: got %b want 0", nack); end
        checks++; if (mst_ack_oe !== 1'b0) begin failures++; $display("FAIL read_master_release: got %b want 0", mst_ack_oe); end
`else
        checks++; if (lat != 1)      begin failures++; $display("FAIL reject_latency: got %0d want 1", lat); end
        checks++; if (nack !== 1'b1) begin failures++; $display("FAIL reject_nack: got %b want 1", nack); end
        checks++; if (rd !== 8'h00)  begin failures++; $display("FAIL reject_rdata: got %h want 00", rd); end
        checks++; if (act !== 1'b0 || start_cnt != s0) begin
            failures++; $display("FAIL reject_bus_quiet: got activity=%b starts=%0d want 0/0", act, start_cnt - s0);
        end
`endif
        $display("test_read: lat=%0d nack=%b rdata=%h", lat, nack, rd);
    endtask

    task automatic test_back_to_back;
        int lat; int b0, s0, p0;
        b0 = bus_bytes.size(); s0 = start_cnt; p0 = stop_cnt;
        @(negedge clk);
        cmd_addr = 7'h50; cmd_rw = 1'b0; cmd_wdata = 8'h11; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_wdata = 8'h22;
        lat = 0;
        while (lat < 2000 && rsp_valid !== 1'b1) begin @(posedge clk); lat++; #1; end
        checks++; if (lat != 320 || cmd_ready !== 1'b1) begin
            failures++; $display("FAIL b2b_first: got lat=%0d ready=%b want 320/1", lat, cmd_ready);
        end
        @(posedge clk); #1;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_second_accept: got busy=%b want 1", busy); end
        cmd_valid = 1'b0;
        lat = 0;
        while (lat < 2000 && rsp_valid !== 1'b1) begin @(posedge clk); lat++; #1; end
        checks++; if (lat != 320 || rsp_nack !== 1'b0) begin
            failures++; $display("FAIL b2b_second: got lat=%0d nack=%b want 320/0", lat, rsp_nack);
        end
        checks++; if (start_cnt - s0 != 2 || stop_cnt - p0 != 2) begin
            failures++; $display("FAIL b2b_start_stop: got %0d/%0d want 2/2", start_cnt - s0, stop_cnt - p0);
        end
        checks++; if (bus_bytes.size() != b0 + 4) begin
            failures++; $display("FAIL b2b_byte_count: got %0d want 4", bus_bytes.size() - b0);
        end else if (bus_bytes[b0+1] !== 8'h11 || bus_bytes[b0+3] !== 8'h22) begin
            failures++; $display("FAIL b2b_bytes: got %h %h want 11 22", bus_bytes[b0+1], bus_bytes[b0+3]);
        end
        $display("test_back_to_back: second lat=%0d", lat);
    endtask

    task automatic test_reset_mid;
        int lat; logic nack; logic [7:0] rd; logic act; logic saw_valid;
        @(negedge clk);
        cmd_addr = 7'h50; cmd_rw = 1'b0; cmd_wdata = 8'hC3; cmd_valid = 1'b1;
        @(posedge clk); #1 cmd_valid = 1'b0;
        // 160 clocks reach DATA, 3 bits later plus one quarter lands in q1 of bit 3.
        repeat (212) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b1 || scl_o !== 1'b0) begin
            failures++; $display("FAIL mid_pre_reset: got busy=%b scl=%b want 1/0", busy, scl_o);
        end
        rst_n = 1'b0;
        #1;
        checks++; if (scl_o !== 1'b1 || sda_oe !== 1'b0) begin
            failures++; $display("FAIL mid_bus_release: got scl=%b sda_oe=%b want 1/0", scl_o, sda_oe);
        end
        saw_valid = 1'b0;
        repeat (4) begin @(negedge clk); if (rsp_valid !== 1'b0) saw_valid = 1'b1; end
        rst_n = 1'b1;
        repeat (20) begin @(negedge clk); if (rsp_valid !== 1'b0) saw_valid = 1'b1; end
        checks++; if (saw_valid !== 1'b0) begin failures++; $display("FAIL mid_no_rsp: got rsp_valid=1 want 0"); end
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL mid_ready: got %b want 1", cmd_ready); end
        run_cmd(7'h50, 1'b0, 8'h5A, lat, nack, rd, act);
        checks++; if (lat != 320 || nack !== 1'b0) begin
            failures++; $display("FAIL mid_recover: got lat=%0d nack=%b want 320/0", lat, nack);
        end
        $display("test_reset_mid: recovery lat=%0d nack=%b", lat, nack);
    endtask

    initial begin
        test_reset();
        test_write();
        test_addr_nack();
        test_read();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
